e203_dtcm_icb_slv: RTL and testbench

- ICB responder (target) end of the LSU-to-DTCM command/response interface.
- Accepts ICB commands, checks alignment, and drives a 1-cycle-latency single-port SRAM.
- Returns one response per command, in order, through a small response buffer that absorbs rsp_ready backpressure.
- Sits between the LSU/DTCM arbiter output and the DTCM RAM macro.

---
 rtl/e203_icb_pkg.sv | 17 +
 rtl/e203_icb_rsp_fifo.sv | 60 ++++++
 rtl/e203_dtcm_icb_slv.sv | 181 ++++++++++++++++++
 tb/tb_e203_dtcm_icb_slv.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_icb_pkg.sv
// Shared ICB definitions for the DTCM responder.
// Size encodings and the buffered response entry layout.
package e203_icb_pkg;

    localparam int ICB_DW = 32;

    localparam logic [1:0] ICB_SZ_B = 2'd0;
    localparam logic [1:0] ICB_SZ_H = 2'd1;
    localparam logic [1:0] ICB_SZ_W = 2'd2;

    typedef struct packed {
        logic              err;
        logic              excl_ok;
        logic [ICB_DW-1:0] rdata;
    } rsp_entry_t;

endpackage

// File: rtl/e203_icb_rsp_fifo.sv
// In-order response buffer for the DTCM ICB responder.
// Ports: clk_i/rst_i (sync, active-high), push_i/din_i, pop_i,
//        head_o (oldest entry), cnt_o (entries held).
module e203_icb_rsp_fifo
    import e203_icb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  rsp_entry_t                   din_i,
    input  logic                         pop_i,
    output rsp_entry_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rsp_entry_t      mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) wptr_d = ptr_inc(wptr_q);
        if (pop_i)  rptr_d = ptr_inc(rptr_q);
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push_i) mem_q[wptr_q] <= din_i;
        end
    end

    assign head_o = mem_q[rptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/e203_dtcm_icb_slv.sv
// ICB responder between the LSU/DTCM arbiter and a 1-cycle DTCM SRAM.
// Cmd side: icb_cmd_* in, icb_cmd_ready out; rsp side: icb_rsp_* out.
// RAM side: ram_cs/we/addr/wem/din out, ram_dout in; slv_idle out.
// Optional exclusive monitor: define E203_DTCM_EXCL_MONITOR_EN.
module e203_dtcm_icb_slv
    import e203_icb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic            icb_cmd_read,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    input  logic            icb_cmd_lock,
    input  logic            icb_cmd_excl,
    input  logic [1:0]      icb_cmd_size,
    input  logic            excl_clr,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic            icb_rsp_err,
    output logic            icb_rsp_excl_ok,
    output logic [DW-1:0]   icb_rsp_rdata,
    output logic            ram_cs,
    output logic            ram_we,
    output logic [AW-3:0]   ram_addr,
    output logic [DW/8-1:0] ram_wem,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout,
    output logic            slv_idle
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          cmd_hsk, misalign;
    logic          excl_ok, excl_fail;
    logic [AW-3:0] word_addr;

    logic s1_vld_q, s1_vld_d;
    logic s1_err_q, s1_err_d;
    logic s1_rd_q, s1_rd_d;
    logic s1_xok_q, s1_xok_d;

    logic [CW-1:0] buf_cnt;
    logic [CW:0]   outstanding;
    logic          buf_empty, push, pop;
    rsp_entry_t    s1_ent, head_ent, rsp_ent;

    logic unused_lock;
    assign unused_lock = icb_cmd_lock;

    // A pop in this cycle does not free a credit until next cycle.
    assign outstanding   = {1'b0, buf_cnt} + {{CW{1'b0}}, s1_vld_q};
    assign icb_cmd_ready = !rst && (outstanding < (CW+1)'(RSP_DEPTH));
    assign cmd_hsk       = icb_cmd_valid && icb_cmd_ready;
    assign word_addr     = icb_cmd_addr[AW-1:2];

    always_comb begin
        unique case (icb_cmd_size)
            ICB_SZ_B: misalign = 1'b0;
            ICB_SZ_H: misalign = icb_cmd_addr[0];
            ICB_SZ_W: misalign = |icb_cmd_addr[1:0];
            default:  misalign = 1'b1;
        endcase
    end

`ifdef E203_DTCM_EXCL_MONITOR_EN
    logic          resv_vld_q, resv_vld_d;
    logic [AW-3:0] resv_addr_q, resv_addr_d;
    logic          resv_hit;

    assign resv_hit = resv_vld_q && (resv_addr_q == word_addr);

    always_comb begin
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
        excl_ok     = 1'b0;
        excl_fail   = 1'b0;
        if (cmd_hsk) begin
            if (icb_cmd_excl && icb_cmd_read) begin
                if (!misalign) begin
                    resv_vld_d  = 1'b1;
                    resv_addr_d = word_addr;
                    excl_ok     = 1'b1;
                end
            end else if (icb_cmd_excl) begin
                // A failed store-conditional must not touch the RAM.
                resv_vld_d = 1'b0;
                excl_ok    = resv_hit && !misalign;
                excl_fail  = !resv_hit;
            end else if (!icb_cmd_read && !misalign && resv_hit) begin
                resv_vld_d = 1'b0;
            end
        end
        if (excl_clr) resv_vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resv_vld_q  <= 1'b0;
            resv_addr_q <= '0;
        end else begin
            resv_vld_q  <= resv_vld_d;
            resv_addr_q <= resv_addr_d;
        end
    end
`else
    logic unused_excl;
    assign unused_excl = icb_cmd_excl ^ excl_clr;
    assign excl_ok     = 1'b0;
    assign excl_fail   = 1'b0;
`endif

    assign ram_cs   = cmd_hsk && !misalign && !excl_fail;
    assign ram_we   = ram_cs && !icb_cmd_read;
    assign ram_addr = word_addr;
    assign ram_wem  = ram_we ? icb_cmd_wmask : '0;
    assign ram_din  = icb_cmd_wdata;

    always_comb begin
        s1_vld_d = cmd_hsk;
        s1_err_d = s1_err_q;
        s1_rd_d  = s1_rd_q;
        s1_xok_d = s1_xok_q;
        if (cmd_hsk) begin
            s1_err_d = misalign;
            s1_rd_d  = icb_cmd_read;
            s1_xok_d = excl_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            s1_rd_q  <= 1'b0;
            s1_xok_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_err_q <= s1_err_d;
            s1_rd_q  <= s1_rd_d;
            s1_xok_q <= s1_xok_d;
        end
    end

    always_comb begin
        s1_ent.err     = s1_err_q;
        s1_ent.excl_ok = s1_xok_q;
        s1_ent.rdata   = (s1_rd_q && !s1_err_q) ? ram_dout : '0;
    end

    // Bypass the buffer only when nothing older is waiting.
    assign buf_empty = (buf_cnt == '0);
    assign pop       = !buf_empty && icb_rsp_ready;
    assign push      = s1_vld_q && (!buf_empty || !icb_rsp_ready);
    assign rsp_ent   = buf_empty ? s1_ent : head_ent;

    e203_icb_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (push),
        .din_i  (s1_ent),
        .pop_i  (pop),
        .head_o (head_ent),
        .cnt_o  (buf_cnt)
    );

    assign icb_rsp_valid   = s1_vld_q || !buf_empty;
    assign icb_rsp_err     = rsp_ent.err;
    assign icb_rsp_excl_ok = rsp_ent.excl_ok;
    assign icb_rsp_rdata   = rsp_ent.rdata;
    assign slv_idle        = (outstanding == '0);

endmodule

// File: tb/tb_e203_dtcm_icb_slv.sv
// Directed bench for e203_dtcm_icb_slv.
// Drives after posedge, checks at negedge against a small SRAM model.
module tb_e203_dtcm_icb_slv;
    import e203_icb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            icb_cmd_valid, icb_cmd_ready;
    logic [AW-1:0]   icb_cmd_addr;
    logic            icb_cmd_read;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_cmd_lock, icb_cmd_excl;
    logic [1:0]      icb_cmd_size;
    logic            excl_clr;
    logic            icb_rsp_valid, icb_rsp_ready;
    logic            icb_rsp_err, icb_rsp_excl_ok;
    logic [DW-1:0]   icb_rsp_rdata;
    logic            ram_cs, ram_we;
    logic [AW-3:0]   ram_addr;
    logic [DW/8-1:0] ram_wem;
    logic [DW-1:0]   ram_din, ram_dout;
    logic            slv_idle;

    int vecs = 0;
    int errs = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    e203_dtcm_icb_slv #(.AW(AW), .DW(DW), .RSP_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .icb_cmd_valid   (icb_cmd_valid),
        .icb_cmd_ready   (icb_cmd_ready),
        .icb_cmd_addr    (icb_cmd_addr),
        .icb_cmd_read    (icb_cmd_read),
        .icb_cmd_wdata   (icb_cmd_wdata),
        .icb_cmd_wmask   (icb_cmd_wmask),
        .icb_cmd_lock    (icb_cmd_lock),
        .icb_cmd_excl    (icb_cmd_excl),
        .icb_cmd_size    (icb_cmd_size),
        .excl_clr        (excl_clr),
        .icb_rsp_valid   (icb_rsp_valid),
        .icb_rsp_ready   (icb_rsp_ready),
        .icb_rsp_err     (icb_rsp_err),
        .icb_rsp_excl_ok (icb_rsp_excl_ok),
        .icb_rsp_rdata   (icb_rsp_rdata),
        .ram_cs          (ram_cs),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wem         (ram_wem),
        .ram_din         (ram_din),
        .ram_dout        (ram_dout),
        .slv_idle        (slv_idle)
    );

    // 1-cycle SRAM with byte write enables.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b])
                        mem[ram_addr[5:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr[5:0]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input logic [15:0] a,
                       input logic rd, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input logic ex);
        icb_cmd_valid = v;
        icb_cmd_addr  = a;
        icb_cmd_read  = rd;
        icb_cmd_size  = sz;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        icb_cmd_excl  = ex;
    endtask

    task automatic idle();
        cmd(1'b0, 16'h0, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        icb_cmd_lock  = 1'b0;
        icb_rsp_ready = 1'b1;
        excl_clr      = 1'b0;
        tick();
        @(negedge clk);
        vecs++;
        if ({icb_cmd_ready, icb_rsp_valid, ram_cs, slv_idle} !== 4'b0001) begin
            errs++;
            $display("FAIL reset_state: got %b want 0001",
                     {icb_cmd_ready, icb_rsp_valid, ram_cs, slv_idle});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (icb_cmd_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_ready: got %b want 1", icb_cmd_ready);
        end
        tick();
    endtask

    task automatic test_word_read();
        cmd(1'b1, 16'h0010, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if ({ram_cs, ram_we, ram_addr} !== {2'b10, 14'h004}) begin
            errs++;
            $display("FAIL read_ram_cmd: got cs=%b we=%b addr=%h want 1 0 004",
                     ram_cs, ram_we, ram_addr);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata}
            !== {3'b100, 32'hDEADBEEF}) begin
            errs++;
            $display("FAIL read_rsp: got v=%b e=%b x=%b d=%h want 1 0 0 deadbeef",
                     icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({slv_idle, icb_rsp_valid} !== 2'b10) begin
            errs++;
            $display("FAIL read_idle: got idle=%b v=%b want 1 0", slv_idle, icb_rsp_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] wm [4];
        wm = '{4'hF, 4'h1, 4'h6, 4'hC};
        for (int i = 0; i < 4; i++) begin
            cmd(1'b1, 16'h0040 + 16'(4*i), 1'b0, ICB_SZ_W,
                {4{8'hA0 + 8'(i)}}, wm[i], 1'b0);
            @(negedge clk);
            vecs++;
            if ({icb_cmd_ready, ram_cs, ram_we, ram_wem, ram_addr}
                !== {3'b111, wm[i], 14'(16 + i)}) begin
                errs++;
                $display("FAIL b2b_wr_cmd%0d: got rdy=%b cs=%b we=%b wem=%h a=%h",
                         i, icb_cmd_ready, ram_cs, ram_we, ram_wem, ram_addr);
            end
            if (i > 0) begin
                vecs++;
                if ({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata} !== {2'b10, 32'h0}) begin
                    errs++;
                    $display("FAIL b2b_wr_rsp%0d: got v=%b e=%b d=%h want 1 0 0",
                             i, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
                end
            end
            tick();
        end
        cmd(1'b1, 16'h0044, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, icb_rsp_err, icb_cmd_ready} !== 3'b101) begin
            errs++;
            $display("FAIL b2b_wr_rsp3: got v=%b e=%b rdy=%b want 1 0 1",
                     icb_rsp_valid, icb_rsp_err, icb_cmd_ready);
        end
        tick();
        cmd(1'b1, 16'h0048, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if (icb_rsp_rdata !== 32'h000000A1) begin
            errs++;
            $display("FAIL b2b_readback1: got %h want 000000a1", icb_rsp_rdata);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if (icb_rsp_rdata !== 32'h00A2A200) begin
            errs++;
            $display("FAIL b2b_readback2: got %h want 00a2a200", icb_rsp_rdata);
        end
        tick();
    endtask

    task automatic test_backpressure();
        icb_rsp_ready = 1'b0;
        cmd(1'b1, 16'h0020, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        tick();
        cmd(1'b1, 16'h0024, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if ({icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata} !== {2'b11, 32'h88880008}) begin
            errs++;
            $display("FAIL bp_second_accept: got rdy=%b v=%b d=%h want 1 1 88880008",
                     icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata);
        end
        tick();
        cmd(1'b1, 16'h0028, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if (icb_cmd_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_third_blocked: got rdy=%b want 0", icb_cmd_ready);
        end
        tick();
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        vecs++;
        if ({icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata} !== {2'b01, 32'h88880008}) begin
            errs++;
            $display("FAIL bp_pop_first: got rdy=%b v=%b d=%h want 0 1 88880008",
                     icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata} !== {2'b11, 32'h99990009}) begin
            errs++;
            $display("FAIL bp_pop_second: got rdy=%b v=%b d=%h want 1 1 99990009",
                     icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, icb_rsp_rdata} !== {1'b1, 32'hAAAA000A}) begin
            errs++;
            $display("FAIL bp_third_rsp: got v=%b d=%h want 1 aaaa000a",
                     icb_rsp_valid, icb_rsp_rdata);
        end
        tick();
        @(negedge clk);
        vecs++;
        if (slv_idle !== 1'b1) begin
            errs++;
            $display("FAIL bp_drained: got idle=%b want 1", slv_idle);
        end
        tick();
    endtask

    task automatic test_misalign();
        cmd(1'b1, 16'h0003, 1'b1, ICB_SZ_H, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if ({icb_cmd_ready, ram_cs} !== 2'b10) begin
            errs++;
            $display("FAIL mis_half_cs: got rdy=%b cs=%b want 1 0", icb_cmd_ready, ram_cs);
        end
        tick();
        cmd(1'b1, 16'h0004, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if ({ram_cs, ram_addr, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}
            !== {1'b1, 14'h001, 2'b11, 32'h0}) begin
            errs++;
            $display("FAIL mis_half_rsp: got cs=%b a=%h v=%b e=%b d=%h",
                     ram_cs, ram_addr, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
        end
        tick();
        cmd(1'b1, 16'h0000, 1'b1, 2'd3, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if ({ram_cs, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}
            !== {3'b010, 32'h0BADF00D}) begin
            errs++;
            $display("FAIL mis_next_word: got cs=%b v=%b e=%b d=%h want 0 1 0 0badf00d",
                     ram_cs, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
        end
        tick();
        cmd(1'b1, 16'h0006, 1'b0, ICB_SZ_W, 32'hFFFFFFFF, 4'hF, 1'b0);
        @(negedge clk);
        vecs++;
        if ({ram_cs, icb_rsp_err, icb_rsp_rdata} !== {2'b01, 32'h0}) begin
            errs++;
            $display("FAIL mis_size3_rsp: got cs=%b e=%b d=%h want 0 1 0",
                     ram_cs, icb_rsp_err, icb_rsp_rdata);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_excl();
`ifdef E203_DTCM_EXCL_MONITOR_EN
        cmd(1'b1, 16'h0020, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b1);
        tick();
        cmd(1'b1, 16'h0020, 1'b0, ICB_SZ_W, 32'h12345678, 4'hF, 1'b1);
        @(negedge clk);
        vecs++;
        if ({ram_cs, ram_we, icb_rsp_excl_ok, icb_rsp_err} !== 4'b1110) begin
            errs++;
            $display("FAIL excl_sc_ok_cmd: got cs=%b we=%b xok=%b e=%b want 1110",
                     ram_cs, ram_we, icb_rsp_excl_ok, icb_rsp_err);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({ram_cs, icb_rsp_excl_ok, icb_rsp_err} !== 3'b010) begin
            errs++;
            $display("FAIL excl_sc_repeat: got cs=%b xok=%b e=%b want 010",
                     ram_cs, icb_rsp_excl_ok, icb_rsp_err);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, icb_rsp_excl_ok, icb_rsp_err} !== 3'b100) begin
            errs++;
            $display("FAIL excl_sc_fail_rsp: got v=%b xok=%b e=%b want 100",
                     icb_rsp_valid, icb_rsp_excl_ok, icb_rsp_err);
        end
        tick();
        cmd(1'b1, 16'h0020, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b1);
        tick();
        idle();
        excl_clr = 1'b1;
        tick();
        excl_clr = 1'b0;
        cmd(1'b1, 16'h0020, 1'b0, ICB_SZ_W, 32'hCAFEF00D, 4'hF, 1'b1);
        @(negedge clk);
        vecs++;
        if (ram_cs !== 1'b0) begin
            errs++;
            $display("FAIL excl_clr_cs: got cs=%b want 0", ram_cs);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, icb_rsp_excl_ok} !== 2'b10) begin
            errs++;
            $display("FAIL excl_clr_rsp: got v=%b xok=%b want 10",
                     icb_rsp_valid, icb_rsp_excl_ok);
        end
        tick();
`else
        cmd(1'b1, 16'h0020, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b1);
        tick();
        cmd(1'b1, 16'h0020, 1'b0, ICB_SZ_W, 32'h12345678, 4'hF, 1'b1);
        @(negedge clk);
        vecs++;
        if ({ram_cs, ram_we, icb_rsp_valid, icb_rsp_excl_ok} !== 4'b1110) begin
            errs++;
            $display("FAIL excl_off_first: got cs=%b we=%b v=%b xok=%b want 1110",
                     ram_cs, ram_we, icb_rsp_valid, icb_rsp_excl_ok);
        end
        tick();
        excl_clr = 1'b1;
        @(negedge clk);
        vecs++;
        if ({ram_cs, ram_we, icb_rsp_excl_ok} !== 3'b110) begin
            errs++;
            $display("FAIL excl_off_repeat: got cs=%b we=%b xok=%b want 110",
                     ram_cs, ram_we, icb_rsp_excl_ok);
        end
        tick();
        excl_clr = 1'b0;
        idle();
        tick();
`endif
    endtask

    task automatic test_reset_flush();
        icb_rsp_ready = 1'b0;
        cmd(1'b1, 16'h0010, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        tick();
        cmd(1'b1, 16'h0044, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        tick();
        idle();
        tick();
        rst = 1'b1;
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, slv_idle} !== 2'b10) begin
            errs++;
            $display("FAIL flush_pre: got v=%b idle=%b want 1 0", icb_rsp_valid, slv_idle);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, slv_idle, icb_cmd_ready, ram_cs} !== 4'b0100) begin
            errs++;
            $display("FAIL flush_post: got v=%b idle=%b rdy=%b cs=%b want 0100",
                     icb_rsp_valid, slv_idle, icb_cmd_ready, ram_cs);
        end
        tick();
        rst = 1'b0;
        icb_rsp_ready = 1'b1;
        cmd(1'b1, 16'h0010, 1'b1, ICB_SZ_W, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        vecs++;
        if ({icb_cmd_ready, ram_cs} !== 2'b11) begin
            errs++;
            $display("FAIL flush_new_cmd: got rdy=%b cs=%b want 11", icb_cmd_ready, ram_cs);
        end
        tick();
        idle();
        @(negedge clk);
        vecs++;
        if ({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errs++;
            $display("FAIL flush_new_rsp: got v=%b e=%b d=%h want 1 0 deadbeef",
                     icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1]  = 32'h0BADF00D;
        mem[4]  = 32'hDEADBEEF;
        mem[8]  = 32'h88880008;
        mem[9]  = 32'h99990009;
        mem[10] = 32'hAAAA000A;
        test_reset();
        test_word_read();
        test_back_to_back();
        test_backpressure();
        test_misalign();
        test_excl();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
